game_score_ctrl: RTL and testbench

- Game-state and score sequencer that drives the display controller's `ingame` and `score` inputs.
- Takes raw button/key levels, synchronises them and detects rising edges.
- Runs a timed round, counts hits up to a cap and holds the final score for the end screen.
- Sits directly upstream of the VGA display stage and runs on the same 25 MHz pixel clock.

---
 rtl/game_score_ctrl.sv | 141 ++++++++++++++
 tb/tb_game_score_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_score_ctrl.sv
// game_score_ctrl: game-state and score sequencer feeding the display stage.
//
// Synchronises the start/hit button levels, detects rising edges, runs a timed
// round that counts hits (with a per-hit cooldown) up to a cap, and holds the
// final score for the end screen. All outputs are registered.
//
// Ports:
//   clk        - 25 MHz pixel clock, all logic on the rising edge
//   reset      - synchronous, active-high reset
//   start_in   - asynchronous start button level
//   hit_in     - asynchronous hit button level
//   ingame     - high while a round is in progress
//   score      - current/final score, 0..MAX_SCORE
//   state      - 00 IDLE, 01 PLAY, 10 OVER
//   round_done - one-cycle pulse on entry to OVER
//   best_score - best round score since reset (GAME_SCORE_HIGH_SCORE_EN),
//                otherwise constant zero
//
// Optional feature macro: GAME_SCORE_HIGH_SCORE_EN enables the best_score register.

module game_score_ctrl #(
  parameter int unsigned MAX_SCORE    = 12,
  parameter int unsigned ROUND_CYCLES = 750000000,
  parameter int unsigned HIT_COOLDOWN = 2500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_in,
  input  logic        hit_in,
  output logic        ingame,
  output logic [31:0] score,
  output logic [1:0]  state,
  output logic        round_done,
  output logic [31:0] best_score
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StOver = 2'b10
  } game_state_e;

  localparam logic [29:0] TimerLoad = 30'(ROUND_CYCLES - 1);
  localparam logic [31:0] CoolLoad  = HIT_COOLDOWN - 1;
  localparam logic [31:0] ScoreCap  = MAX_SCORE;

  game_state_e fsm_state;
  logic [29:0] timer;
  logic [31:0] cooldown;

  // Two-flop synchronisers, previous-value flops and registered edge pulses.
  logic start_s1, start_s2, start_prev, start_edge;
  logic hit_s1, hit_s2, hit_prev, hit_edge;

  logic hit_ok;
  assign hit_ok = hit_edge && (cooldown == 32'd0) && (score < ScoreCap);

  always_ff @(posedge clk) begin
    if (reset) begin
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_prev <= 1'b0;
      start_edge <= 1'b0;
      hit_s1     <= 1'b0;
      hit_s2     <= 1'b0;
      hit_prev   <= 1'b0;
      hit_edge   <= 1'b0;
    end else begin
      start_s1   <= start_in;
      start_s2   <= start_s1;
      start_prev <= start_s2;
      start_edge <= start_s2 & ~start_prev;
      hit_s1     <= hit_in;
      hit_s2     <= hit_s1;
      hit_prev   <= hit_s2;
      hit_edge   <= hit_s2 & ~hit_prev;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_state  <= StIdle;
      ingame     <= 1'b0;
      score      <= 32'd0;
      round_done <= 1'b0;
      timer      <= 30'd0;
      cooldown   <= 32'd0;
    end else begin
      round_done <= 1'b0;
      unique case (fsm_state)
        StIdle, StOver: begin
          if (start_edge) begin
            fsm_state <= StPlay;
            ingame    <= 1'b1;
            score     <= 32'd0;
            timer     <= TimerLoad;
            cooldown  <= 32'd0;
          end
        end
        StPlay: begin
          if (cooldown != 32'd0) cooldown <= cooldown - 32'd1;
          if (timer != 30'd0) timer <= timer - 30'd1;
          // A hit on the final timer cycle still counts before the round closes.
          if (hit_ok) begin
            score    <= score + 32'd1;
            cooldown <= CoolLoad;
          end
          if ((timer == 30'd0) || (score == ScoreCap)) begin
            fsm_state  <= StOver;
            ingame     <= 1'b0;
            round_done <= 1'b1;
          end
        end
        default: begin
          fsm_state <= StIdle;
          ingame    <= 1'b0;
        end
      endcase
    end
  end

  assign state = fsm_state;

`ifdef GAME_SCORE_HIGH_SCORE_EN
  logic [31:0] best;

  // round_done marks the OVER-entry cycle, when score holds the final value.
  always_ff @(posedge clk) begin
    if (reset) begin
      best <= 32'd0;
    end else if (round_done && (score > best)) begin
      best <= score;
    end
  end

  assign best_score = best;
`else
  assign best_score = 32'd0;
`endif

endmodule

// File: tb/tb_game_score_ctrl.sv
// Bench for game_score_ctrl: scripted vector table, hand-written corner
// sequences and random stimulus, all checked against a round-level model.

module tb_game_score_ctrl;

  localparam int unsigned MaxScore    = 12;
  localparam int unsigned RoundCycles = 100;
  localparam int unsigned HitCooldown = 4;

`ifdef GAME_SCORE_HIGH_SCORE_EN
  localparam bit HsEn = 1'b1;
`else
  localparam bit HsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_in = 1'b0;
  logic        hit_in = 1'b0;
  logic        ingame;
  logic [31:0] score;
  logic [1:0]  state;
  logic        round_done;
  logic [31:0] best_score;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  game_score_ctrl #(
    .MAX_SCORE   (MaxScore),
    .ROUND_CYCLES(RoundCycles),
    .HIT_COOLDOWN(HitCooldown)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_in  (start_in),
    .hit_in    (hit_in),
    .ingame    (ingame),
    .score     (score),
    .state     (state),
    .round_done(round_done),
    .best_score(best_score)
  );

  // Round-level reference model: mode 0 idle, 1 play, 2 over.
  int m_mode, m_score, m_best, m_cyc, m_play_start, m_last_hit;
  bit m_rd;
  bit sp1, sp2, sp3, sp4, hp1, hp2, hp3, hp4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic s, input logic h);
    bit es, eh, over, prev_rd;
    int prev_score;
    if (r) begin
      m_mode = 0; m_score = 0; m_best = 0; m_rd = 0; m_cyc = 0;
      m_play_start = 0; m_last_hit = -1000000;
      {sp1, sp2, sp3, sp4, hp1, hp2, hp3, hp4} = '0;
    end else begin
      m_cyc++;
      // A pin level takes effect three edges after it is sampled.
      es = sp3 & ~sp4;
      eh = hp3 & ~hp4;
      {sp4, sp3, sp2, sp1} = {sp3, sp2, sp1, s};
      {hp4, hp3, hp2, hp1} = {hp3, hp2, hp1, h};
      prev_rd = m_rd;
      prev_score = m_score;
      m_rd = 0;
      if (HsEn && prev_rd && (prev_score > m_best)) m_best = prev_score;
      if (m_mode != 1) begin
        if (es) begin
          m_mode = 1; m_score = 0; m_play_start = m_cyc; m_last_hit = -1000000;
        end
      end else begin
        over = ((m_cyc - m_play_start) >= int'(RoundCycles)) || (m_score == int'(MaxScore));
        if (eh && (m_score < int'(MaxScore)) && ((m_cyc - m_last_hit) >= int'(HitCooldown))) begin
          m_score++;
          m_last_hit = m_cyc;
        end
        if (over) begin
          m_mode = 2; m_rd = 1;
        end
      end
    end
  endtask

  // Apply inputs at the falling edge, clock once, compare at the next falling edge.
  task automatic step(input logic r, input logic s, input logic h);
    reset = r; start_in = s; hit_in = h;
    @(posedge clk);
    model_edge(r, s, h);
    @(negedge clk);
    check("m_state", {30'd0, state}, 32'(m_mode));
    check("m_ingame", {31'd0, ingame}, {31'd0, m_mode == 1});
    check("m_score", score, 32'(m_score));
    check("m_round_done", {31'd0, round_done}, {31'd0, m_rd});
    check("m_best", best_score, 32'(m_best));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  // Start pulse then three edges: ends on the PLAY-entry edge.
  task automatic start_round();
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    check("start_round_state", {30'd0, state}, 32'd1);
  endtask

  task automatic hit_pulse(input int gap);
    step(1'b0, 1'b0, 1'b1);
    idle(gap - 1);
  endtask

  task automatic wait_over();
    for (int i = 0; i < 200 && state != 2'b10; i++) idle(1);
    check("wait_over", {30'd0, state}, 32'd2);
    idle(2);
  endtask

  typedef struct {
    logic       rst;
    logic       st;
    logic       ht;
    int         n;
    logic [1:0] state_e;
    int         score_e;
    logic       ingame_e;
    logic       rd_e;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic h, input int n,
                     input logic [1:0] se, input int sc, input logic ig, input logic rd);
    vec_t v;
    v.rst = r; v.st = s; v.ht = h; v.n = n;
    v.state_e = se; v.score_e = sc; v.ingame_e = ig; v.rd_e = rd;
    tbl.push_back(v);
  endtask

  initial begin
    model_edge(1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Scripted round: reset, start, three hits, stray start, timeout, restart, reset.
    add(1, 1, 1, 3,  2'd0, 0, 0, 0);
    add(0, 1, 0, 3,  2'd0, 0, 0, 0);
    add(0, 1, 0, 1,  2'd1, 0, 1, 0);
    add(0, 0, 0, 10, 2'd1, 0, 1, 0);
    add(0, 0, 1, 1,  2'd1, 0, 1, 0);
    add(0, 0, 0, 9,  2'd1, 1, 1, 0);
    add(0, 0, 1, 1,  2'd1, 1, 1, 0);
    add(0, 0, 0, 9,  2'd1, 2, 1, 0);
    add(0, 0, 1, 1,  2'd1, 2, 1, 0);
    add(0, 0, 0, 9,  2'd1, 3, 1, 0);
    add(0, 1, 0, 1,  2'd1, 3, 1, 0);
    add(0, 0, 0, 58, 2'd1, 3, 1, 0);
    add(0, 0, 0, 1,  2'd2, 3, 0, 1);
    add(0, 0, 0, 1,  2'd2, 3, 0, 0);
    add(0, 1, 0, 1,  2'd2, 3, 0, 0);
    add(0, 0, 0, 2,  2'd2, 3, 0, 0);
    add(0, 0, 0, 1,  2'd1, 0, 1, 0);
    add(0, 0, 0, 49, 2'd1, 0, 1, 0);
    add(1, 0, 0, 1,  2'd0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].n; c++) step(tbl[i].rst, tbl[i].st, tbl[i].ht);
      check($sformatf("tbl%0d_state", i), {30'd0, state}, {30'd0, tbl[i].state_e});
      check($sformatf("tbl%0d_score", i), score, 32'(tbl[i].score_e));
      check($sformatf("tbl%0d_ingame", i), {31'd0, ingame}, {31'd0, tbl[i].ingame_e});
      check($sformatf("tbl%0d_round_done", i), {31'd0, round_done}, {31'd0, tbl[i].rd_e});
    end

    // Cooldown: hit edges two cycles apart, then one long held level.
    do_reset();
    start_round();
    for (int i = 0; i < 4; i++) hit_pulse(2);
    idle(4);
    check("cooldown_alt", score, 32'd2);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1);
    idle(4);
    check("cooldown_held", score, 32'd3);
    wait_over();

    // Cap: 15 hits five cycles apart; round closes the edge after the 12th.
    do_reset();
    start_round();
    for (int i = 0; i < 11; i++) hit_pulse(5);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    check("cap_score", score, 32'd12);
    check("cap_still_play", {30'd0, state}, 32'd1);
    idle(1);
    check("cap_over", {30'd0, state}, 32'd2);
    check("cap_round_done", {31'd0, round_done}, 32'd1);
    for (int i = 0; i < 3; i++) hit_pulse(5);
    check("cap_frozen", score, 32'd12);

    // Hit edge landing on the final timer cycle.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    idle(99);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    check("t0_play", {30'd0, state}, 32'd1);
    check("t0_score_before", score, 32'd0);
    idle(1);
    check("t0_over", {30'd0, state}, 32'd2);
    check("t0_score", score, 32'd1);

    // Best score across rounds scoring 5 then 3.
    do_reset();
    start_round();
    for (int i = 0; i < 5; i++) hit_pulse(5);
    wait_over();
    check("best_r1", best_score, HsEn ? 32'd5 : 32'd0);
    start_round();
    check("restart_score", score, 32'd0);
    for (int i = 0; i < 3; i++) hit_pulse(5);
    wait_over();
    check("best_r2_score", score, 32'd3);
    check("best_r2", best_score, HsEn ? 32'd5 : 32'd0);

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 599) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
